cart_sram_backup: RTL
=====================

Name: cart_sram_backup

Overview:
- Battery-backed SRAM store that sits directly downstream of the cartridge mapper.
- Consumes the mapper's SRAM strobes and 13-bit SRAM address, holds the 8 KB save RAM, and serves CPU reads and writes.
- Mirrors the RAM to and from a mounted save image through the MiSTer sector interface: 512-byte sectors, sd_rd/sd_wr/sd_ack handshake.
- Tracks dirty state so the host can flush on request.

Parameters:
- ADDR_W, 13, SRAM address width; RAM size is 2^ADDR_W bytes.
- SECT_W, 9, sector byte-address width (512-byte sectors); sector count N = 2^(ADDR_W-SECT_W) = 16.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sram_addr  in  ADDR_W  byte address from mapper
- sram_din  in  8  CPU write data
- sram_we  in  1  CPU write strobe, one byte per high cycle
- sram_oe  in  1  CPU read select
- sram_dout  out  8  read data, valid 1 cycle after sram_oe/sram_addr; 8'hFF while busy
- img_mounted  in  1  pulse: save image (re)mounted
- img_size  in  32  image size in bytes
- save_req  in  1  pulse: flush RAM to image
- sd_lba  out  32  sector number
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  host acknowledge, high for the whole sector transfer
- sd_buff_addr  in  SECT_W  byte index within sector
- sd_buff_dout  in  8  host->RAM data
- sd_buff_wr  in  1  host->RAM byte strobe (qualified by sd_ack)
- sd_buff_din  out  8  RAM->host data, 1-cycle latency from sd_buff_addr
- busy  out  1  load or save in progress
- dirty  out  1  RAM modified since last load/save

Behaviour:
- Reset (reset_n low at clk edge): state=IDLE; sd_rd=0, sd_wr=0, sd_lba=0, busy=0, dirty=0, mounted=0, sector counter=0.
  - RAM contents are not cleared.
  - An in-flight transfer is abandoned; no request is re-issued after reset.
- mounted flag: on img_mounted, mounted <= (img_size != 0). last_sect = min(ceil(img_size/512), N) - 1.
- FSM states: IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER.
- IDLE:
  - img_mounted with img_size != 0 -> RD_REQ, sect=0.
  - Else save_req with mounted & dirty -> WR_REQ, sect=0, dirty cleared in the same cycle.
  - If img_mounted and save_req coincide, img_mounted wins and save_req is dropped.
  - save_req while not dirty or not mounted: ignored.
- RD_REQ: sd_rd=1, sd_lba=sect. On sd_ack high -> RD_XFER and sd_rd=0 that cycle.
- RD_XFER: each sd_buff_wr & sd_ack writes sd_buff_dout to RAM[{sect, sd_buff_addr}]. On sd_ack falling:
  - If sect == last_sect -> IDLE, dirty=0.
  - Else sect+1 -> RD_REQ.
- WR_REQ/WR_XFER: mirror of read, using sd_wr. sd_buff_din = RAM[{sect, sd_buff_addr}] registered (1 cycle). The whole of sectors 0..last_sect is written.
- busy = (state != IDLE).
- CPU access while busy:
  - During load: CPU writes are discarded and reads return FF.
  - During save: CPU reads and writes proceed normally. A write sets dirty=1 again; if it lands in the same cycle as the save-start clear, set wins. The image may then hold a mix of old and new data; the next save corrects it.
- dirty set on any accepted sram_we when not loading.
- sram_we and sram_oe both high: the write is performed, and dout shows the old byte the next cycle (read-before-write).
- img_mounted during RD/WR: ignored until IDLE.
- sd_ack high in IDLE: ignored; no RAM writes.
- Sector counter width ADDR_W-SECT_W; it never wraps because last_sect <= N-1.

Decomposition:
- Shared package (cart_pkg): SRAM_ADDR_W=13, SECT_W=9, state enum for the backup FSM.
- One sub-module, cart_sram_dpram: true dual-port 2^ADDR_W x 8 RAM with registered outputs.
  - Port A: CPU.
  - Port B: sector interface.
  - Write-to-same-address collision between ports: port A data is stored.
- FSM and dirty logic stay in cart_sram_backup.

Test Plan:
- Reset then mount with img_size=8192:
  - sd_rd rises with sd_lba=0; host acks and writes bytes 0x00..0xFF pattern.
  - Required: 16 sectors read (lba 0..15), busy falls after the last sd_ack falls, dirty=0.
  - CPU read of addr 0x0005 returns the loaded byte next cycle.
- Mount with img_size=1000:
  - Required: exactly 2 sector reads (lba 0,1); no third sd_rd.
- CPU write 0x5A to 0x1FFF, then save_req:
  - Required: dirty=1 before the save and 0 at save start; sd_wr issued for lba 0..15.
  - Sector 15, byte 511 shows 0x5A on sd_buff_din one cycle after sd_buff_addr=511.
- save_req with dirty=0, then save_req with img_size=0 mounted:
  - Required: no sd_wr in either case, busy stays 0.
- CPU write during save sector 3:
  - Required: save completes all 16 sectors and dirty=1 afterwards.
  - Same-cycle write and save start: dirty=1.
- Assert reset_n=0 mid-RD_XFER of sector 7:
  - Required: next cycle sd_rd=0, busy=0, dirty=0.
  - Later sd_ack/sd_buff_wr activity does not modify RAM.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge save-RAM block: address widths and
// the backup FSM state encoding.
package cart_pkg;
  localparam int SRAM_ADDR_W = 13;
  localparam int SECT_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_XFER,
    ST_WR_REQ,
    ST_WR_XFER
  } bk_state_e;
endpackage

// File: rtl/cart_sram_dpram.sv
// True dual-port byte RAM with registered read data on both ports.
// Port A is the CPU side and wins a same-address write collision with port B.
module cart_sram_dpram
  import cart_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [7:0]        a_din_i,
  input  logic              a_we_i,
  input  logic              a_re_i,
  output logic [7:0]        a_dout_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [7:0]        b_din_i,
  input  logic              b_we_i,
  output logic [7:0]        b_dout_o
);
  logic [7:0] mem_q [2**ADDR_W];

  // Reads sample the old contents; the port A write is last so it overrides B.
  always_ff @(posedge clk) begin
    if (a_re_i) a_dout_o <= mem_q[a_addr_i];
    b_dout_o <= mem_q[b_addr_i];
    if (b_we_i) mem_q[b_addr_i] <= b_din_i;
    if (a_we_i) mem_q[a_addr_i] <= a_din_i;
  end
endmodule

// File: rtl/cart_sram_backup.sv
// Battery-backed save RAM behind the cartridge mapper, mirrored to a mounted
// save image one 512-byte sector at a time through the host sector interface.
module cart_sram_backup
  import cart_pkg::*;
#(
  parameter int ADDR_W = cart_pkg::SRAM_ADDR_W,
  parameter int SECT_W = cart_pkg::SECT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_din,
  input  logic              sram_we,
  input  logic              sram_oe,
  output logic [7:0]        sram_dout,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic              save_req,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [SECT_W-1:0] sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic              busy,
  output logic              dirty
);
  localparam int SC_W  = ADDR_W - SECT_W;
  localparam int NSECT = 1 << SC_W;

  bk_state_e       state_q;
  logic [SC_W-1:0] sect_q;
  logic [SC_W-1:0] last_q;
  logic [SC_W-1:0] last_d;
  logic [31:0]     sd_lba_q;
  logic            sd_rd_q;
  logic            sd_wr_q;
  logic            mounted_q;
  logic            dirty_q;
  logic            dirty_d;
  logic            ff_q;

  logic            loading;
  logic            cpu_we;
  logic            sd_we;
  logic            load_start;
  logic            save_start;
  logic            load_done;
  logic [31:0]     nsect;
  logic [7:0]      ram_a_dout;

  always_comb begin
    loading    = (state_q == ST_RD_REQ) || (state_q == ST_RD_XFER);
    cpu_we     = sram_we && !loading;
    sd_we      = (state_q == ST_RD_XFER) && sd_ack && sd_buff_wr;
    load_start = (state_q == ST_IDLE) && img_mounted && (img_size != 32'd0);
    save_start = (state_q == ST_IDLE) && !img_mounted && save_req && mounted_q && dirty_q;
    load_done  = (state_q == ST_RD_XFER) && !sd_ack && (sect_q == last_q);
  end

  // Sector count of the image, rounded up and clamped to the RAM size.
  always_comb begin
    nsect  = (img_size >> SECT_W) + 32'(|img_size[SECT_W-1:0]);
    last_d = (nsect >= 32'(NSECT)) ? SC_W'(NSECT - 1) : SC_W'(nsect - 32'd1);
  end

  // A CPU write landing on the save-start cycle must leave the RAM marked dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (save_start || load_done) dirty_d = 1'b0;
    if (cpu_we) dirty_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sect_q    <= '0;
      last_q    <= '0;
      sd_lba_q  <= 32'd0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      mounted_q <= 1'b0;
      dirty_q   <= 1'b0;
      ff_q      <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      ff_q    <= loading;
      case (state_q)
        ST_IDLE: begin
          if (img_mounted) begin
            mounted_q <= (img_size != 32'd0);
            last_q    <= last_d;
          end
          if (load_start) begin
            state_q  <= ST_RD_REQ;
            sect_q   <= '0;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b1;
          end else if (save_start) begin
            state_q  <= ST_WR_REQ;
            sect_q   <= '0;
            sd_lba_q <= 32'd0;
            sd_wr_q  <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (sd_ack) begin
            state_q <= ST_RD_XFER;
            sd_rd_q <= 1'b0;
          end
        end
        ST_RD_XFER: begin
          if (!sd_ack) begin
            if (sect_q == last_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q  <= ST_RD_REQ;
              sect_q   <= sect_q + SC_W'(1);
              sd_lba_q <= 32'(sect_q) + 32'd1;
              sd_rd_q  <= 1'b1;
            end
          end
        end
        ST_WR_REQ: begin
          if (sd_ack) begin
            state_q <= ST_WR_XFER;
            sd_wr_q <= 1'b0;
          end
        end
        ST_WR_XFER: begin
          if (!sd_ack) begin
            if (sect_q == last_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q  <= ST_WR_REQ;
              sect_q   <= sect_q + SC_W'(1);
              sd_lba_q <= 32'(sect_q) + 32'd1;
              sd_wr_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  cart_sram_dpram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (clk),
    .a_addr_i (sram_addr),
    .a_din_i  (sram_din),
    .a_we_i   (cpu_we),
    .a_re_i   (sram_oe || sram_we),
    .a_dout_o (ram_a_dout),
    .b_addr_i ({sect_q, sd_buff_addr}),
    .b_din_i  (sd_buff_dout),
    .b_we_i   (sd_we),
    .b_dout_o (sd_buff_din)
  );

  assign sram_dout = ff_q ? 8'hFF : ram_a_dout;
  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign busy      = (state_q != ST_IDLE);
  assign dirty     = dirty_q;
endmodule
